// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI host: transfer FSM states, default widths and
// the character-length encoding used by the command interface.
package spi_host_pkg;

  localparam int LEN_W_DEF = 7;
  localparam int SS_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } xfer_state_e;

  // A length field of zero encodes the largest character, 2^len_w bits.
  function automatic int unsigned char_bits(input int unsigned len,
                                            input int unsigned len_w);
    if (len == 0) return 32'd1 << len_w;
    return len;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl.sv
// SPI character transfer sequencer: drives slave selects and the spi_clgen
// enable/go/last_clk controls, counts neg edges, applies CS setup/hold gaps.
module spi_xfer_ctrl
  import spi_host_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int SS_W  = SS_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [SS_W-1:0]  cmd_ss_i,
  input  logic [7:0]       cs_delay_i,
  input  logic             abort_i,
  output logic             clk_en_o,
  output logic             clk_go_o,
  output logic             last_clk_o,
  input  logic             pos_edge_i,
  input  logic             neg_edge_i,
  output logic [SS_W-1:0]  ss_n_o,
  output logic [LEN_W:0]   bit_cnt_o,
  output logic             busy_o,
  output logic             done_o
);

  xfer_state_e      state_q, state_d;
  logic [7:0]       dly_q, dly_d;
  logic [LEN_W:0]   bit_q, bit_d;
  logic [SS_W-1:0]  mask_q, mask_d;
  logic [LEN_W:0]   bit_load;
  logic             unused_pos_edge;

  // Bits are counted on the shifting edge only; the sampling edge is not needed.
  assign unused_pos_edge = pos_edge_i;

  function automatic logic [7:0] dec_dly(input logic [7:0] v);
    return (v == '0) ? v : v - 8'd1;
  endfunction

  function automatic logic [LEN_W:0] dec_bit(input logic [LEN_W:0] v);
    return (v == '0) ? v : v - (LEN_W+1)'(1);
  endfunction

  assign bit_load = (LEN_W+1)'(char_bits(32'(cmd_len_i), 32'(LEN_W)));

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    bit_d   = bit_q;
    mask_d  = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          bit_d   = bit_load;
          mask_d  = cmd_ss_i;
          dly_d   = cs_delay_i;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (dly_q == '0) state_d = ST_XFER;
        else             dly_d   = dec_dly(dly_q);
      end
      ST_XFER: begin
        if (neg_edge_i) begin
          bit_d = dec_bit(bit_q);
          if (bit_q <= (LEN_W+1)'(1)) begin
            dly_d   = cs_delay_i;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (dly_q == '0) state_d = ST_IDLE;
        else             dly_d   = dec_dly(dly_q);
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides any same-cycle edge or delay expiry.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      bit_d   = '0;
      dly_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      bit_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      bit_q   <= bit_d;
      mask_q  <= mask_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign ss_n_o      = (state_q == ST_IDLE) ? '1 : ~mask_q;
  assign clk_en_o    = (state_q == ST_XFER);
  assign clk_go_o    = (state_q == ST_SETUP) && (dly_q == '0);
  assign last_clk_o  = (state_q == ST_XFER) && (bit_q == (LEN_W+1)'(1));
  assign done_o      = (state_q == ST_HOLD) && (dly_q == '0);
  assign bit_cnt_o   = bit_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: table of transfers plus abort, back-to-back
// and reset-in-HOLD sequences. Neg edges are emitted every other XFER cycle.
module tb_spi_xfer_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [6:0] cmd_len_i = '0;
  logic [7:0] cmd_ss_i = '0;
  logic [7:0] cs_delay_i = '0;
  logic       abort_i = 1'b0;
  logic       clk_en_o, clk_go_o, last_clk_o;
  logic       pos_edge_i = 1'b0;
  logic       neg_edge_i = 1'b0;
  logic [7:0] ss_n_o;
  logic [7:0] bit_cnt_o;
  logic       busy_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  spi_xfer_ctrl #(.LEN_W(7), .SS_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_len_i(cmd_len_i), .cmd_ss_i(cmd_ss_i), .cs_delay_i(cs_delay_i),
    .abort_i(abort_i),
    .clk_en_o(clk_en_o), .clk_go_o(clk_go_o), .last_clk_o(last_clk_o),
    .pos_edge_i(pos_edge_i), .neg_edge_i(neg_edge_i),
    .ss_n_o(ss_n_o), .bit_cnt_o(bit_cnt_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0] len;
    logic [7:0] dly;
    logic [7:0] mask;
    int         bits;
    logic [7:0] ssn;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic run_vec(input vec_t v);
    chk("idle_ready", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_len_i = v.len; cmd_ss_i = v.mask; cs_delay_i = v.dly;
    tick();
    cmd_valid_i = 1'b0;
    chk("setup_busy", 32'(busy_o), 32'd1);
    chk("setup_ss_n", 32'(ss_n_o), 32'(v.ssn));
    chk("load_bits", 32'(bit_cnt_o), 32'(v.bits));
    chk("setup_ready", 32'(cmd_ready_o), 32'd0);
    for (int k = 0; k <= int'(v.dly); k++) begin
      chk("setup_go", 32'(clk_go_o), 32'(k == int'(v.dly)));
      chk("setup_en", 32'(clk_en_o), 32'd0);
      tick();
    end
    for (int i = 1; i <= v.bits; i++) begin
      neg_edge_i = 1'b0;
      tick();
      chk("xfer_en", 32'(clk_en_o), 32'd1);
      chk("xfer_bits", 32'(bit_cnt_o), 32'(v.bits - i + 1));
      chk("xfer_last", 32'(last_clk_o), 32'(i == v.bits));
      neg_edge_i = 1'b1;
      tick();
    end
    neg_edge_i = 1'b0;
    chk("hold_en", 32'(clk_en_o), 32'd0);
    chk("hold_bits", 32'(bit_cnt_o), 32'd0);
    chk("hold_last", 32'(last_clk_o), 32'd0);
    for (int k = 0; k <= int'(v.dly); k++) begin
      chk("hold_done", 32'(done_o), 32'(k == int'(v.dly)));
      chk("hold_ss_n", 32'(ss_n_o), 32'(v.ssn));
      tick();
    end
    chk("end_ready", 32'(cmd_ready_o), 32'd1);
    chk("end_ss_n", 32'(ss_n_o), 32'hFF);
    chk("end_done", 32'(done_o), 32'd0);
    chk("end_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    tbl[0] = '{7'd8, 8'd2, 8'h01, 8,   8'hFE};
    tbl[1] = '{7'd0, 8'd1, 8'h10, 128, 8'hEF};
    tbl[2] = '{7'd1, 8'd0, 8'h80, 1,   8'h7F};
    tbl[3] = '{7'd5, 8'd3, 8'h0C, 5,   8'hF3};

    // Reset state
    tick();
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_ss_n", 32'(ss_n_o), 32'hFF);
    chk("rst_en", 32'(clk_en_o), 32'd0);
    chk("rst_go", 32'(clk_go_o), 32'd0);
    chk("rst_last", 32'(last_clk_o), 32'd0);
    chk("rst_bits", 32'(bit_cnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    tick();

    foreach (tbl[t]) begin
      run_vec(tbl[t]);
      tick();
    end

    // Abort at bit 3 of 8, coinciding with a neg edge
    cmd_valid_i = 1'b1; cmd_len_i = 7'd8; cmd_ss_i = 8'h04; cs_delay_i = 8'd1;
    tick();
    cmd_valid_i = 1'b0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      neg_edge_i = 1'b0; tick();
      neg_edge_i = 1'b1; tick();
    end
    neg_edge_i = 1'b0;
    chk("abort_pre_bits", 32'(bit_cnt_o), 32'd6);
    chk("abort_pre_en", 32'(clk_en_o), 32'd1);
    neg_edge_i = 1'b1; abort_i = 1'b1;
    tick();
    neg_edge_i = 1'b0; abort_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_ss_n", 32'(ss_n_o), 32'hFF);
    chk("abort_en", 32'(clk_en_o), 32'd0);
    chk("abort_bits", 32'(bit_cnt_o), 32'd0);
    chk("abort_ready", 32'(cmd_ready_o), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("abort_no_done", 32'(done_o), 32'd0);
      tick();
    end

    // Abort in IDLE is ignored; the concurrent command is accepted
    cmd_valid_i = 1'b1; abort_i = 1'b1; cmd_len_i = 7'd4; cmd_ss_i = 8'h20; cs_delay_i = 8'd3;
    tick();
    cmd_valid_i = 1'b0; abort_i = 1'b0;
    chk("idle_abort_busy", 32'(busy_o), 32'd1);
    chk("idle_abort_ss_n", 32'(ss_n_o), 32'hDF);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("setup_abort_busy", 32'(busy_o), 32'd0);
    tick();

    // Back-to-back commands with valid held high
    cmd_valid_i = 1'b1; cmd_len_i = 7'd2; cmd_ss_i = 8'h01; cs_delay_i = 8'd1;
    tick();
    cmd_len_i = 7'd1; cmd_ss_i = 8'h80;
    chk("b2b_first_ss_n", 32'(ss_n_o), 32'hFE);
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      neg_edge_i = 1'b0; tick();
      neg_edge_i = 1'b1; tick();
    end
    neg_edge_i = 1'b0;
    chk("b2b_hold0_done", 32'(done_o), 32'd0);
    tick();
    chk("b2b_hold1_done", 32'(done_o), 32'd1);
    chk("b2b_hold1_ready", 32'(cmd_ready_o), 32'd0);
    tick();
    chk("b2b_gap_ready", 32'(cmd_ready_o), 32'd1);
    chk("b2b_gap_ss_n", 32'(ss_n_o), 32'hFF);
    tick();
    cmd_valid_i = 1'b0;
    chk("b2b_second_busy", 32'(busy_o), 32'd1);
    chk("b2b_second_ss_n", 32'(ss_n_o), 32'h7F);
    chk("b2b_second_bits", 32'(bit_cnt_o), 32'd1);
    tick(); tick();
    neg_edge_i = 1'b0; tick();
    chk("b2b_second_last", 32'(last_clk_o), 32'd1);
    neg_edge_i = 1'b1; tick();
    neg_edge_i = 1'b0;
    tick();
    chk("b2b_second_done", 32'(done_o), 32'd1);
    chk("b2b_second_hold_ss_n", 32'(ss_n_o), 32'h7F);
    tick();
    chk("b2b_second_idle", 32'(cmd_ready_o), 32'd1);

    // Asynchronous reset in HOLD
    cmd_valid_i = 1'b1; cmd_len_i = 7'd1; cmd_ss_i = 8'h02; cs_delay_i = 8'd4;
    tick();
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    neg_edge_i = 1'b0; tick();
    neg_edge_i = 1'b1; tick();
    neg_edge_i = 1'b0;
    tick();
    chk("prerst_hold_busy", 32'(busy_o), 32'd1);
    chk("prerst_hold_ss_n", 32'(ss_n_o), 32'hFD);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_ready", 32'(cmd_ready_o), 32'd1);
    chk("arst_ss_n", 32'(ss_n_o), 32'hFF);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_bits", 32'(bit_cnt_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_en", 32'(clk_en_o), 32'd0);
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("arst_no_done", 32'(done_o), 32'd0);
      chk("arst_idle", 32'(busy_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
